pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Holds the program counter and drives it to the PC+4 and branch-target adders. It selects the next PC from the adder results, fetches instructions from instruction memory over a valid/ready request channel, and buffers returned instructions with their PC in a small FIFO for decode. It sits directly upstream of the adders and consumes their 64-bit sums.

Parameters:
XLEN, 64, PC and adder-result width
INSTR_W, 32, instruction width
RESET_PC, 64'h0, PC value loaded on reset
BUF_DEPTH, 2, fetch-buffer entries; only 2 is supported

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
pc_out  out  XLEN  current PC; feeds the adders and is the imem request address
pc_plus4  in  XLEN  pc_out+4 from the adder, combinational
branch_target  in  XLEN  redirect target from the adder
branch_taken  in  1  redirect strobe, one cycle
stall  in  1  suppresses new requests
imem_req_valid  out  1  request valid; address is pc_out
imem_req_ready  in  1  memory accepts request
imem_rsp_valid  in  1  response valid, at least 1 cycle after accept
imem_rsp_instr  in  INSTR_W  response data
inst_valid  out  1  buffer head valid
inst_ready  in  1  decode consumes head
inst_out  out  INSTR_W  head instruction
inst_pc  out  XLEN  head PC

Behaviour:
- Reset (async assert, sync release):
  - PC=RESET_PC, state=REQ, buffer empty.
  - Outputs: inst_valid=0, inst_out=0, inst_pc=0, imem_req_valid=0.
- States:
  - REQ: may issue a request.
  - WAIT: one request outstanding.
  - DROP: one request outstanding whose response must be discarded.
  - At most one request is outstanding.
- imem_req_valid = (state==REQ) & ~stall & ~branch_taken & (count<BUF_DEPTH). The signal is combinational.
- Request accepted (valid&ready):
  - PC<=pc_plus4; the PC of the request is latched into the tag register; REQ->WAIT.
  - Fetch latency is 1 cycle minimum from accept to response.
- In WAIT, imem_rsp_valid pushes {tag PC, instr} into the buffer and moves to REQ. A request may be issued again in that same next cycle.
- Redirect (branch_taken=1):
  - PC<=branch_target and the buffer is flushed (count=0). inst_valid is 0 from the next cycle.
  - REQ->REQ. WAIT->DROP. DROP stays in DROP.
  - Redirect has priority over stall and over a same-cycle pop.
- Redirect together with imem_rsp_valid in WAIT: the response is discarded, the state goes to REQ, and PC is still redirected.
- DROP: imem_rsp_valid is discarded and the state goes to REQ.
- Stall: no new requests are issued. An outstanding response is still captured, the PC holds, and the buffer may still drain.
- Buffer:
  - FIFO of depth 2.
  - Pop when inst_valid&inst_ready. Push and pop in the same cycle is legal, with count unchanged.
  - Push never occurs when full, because issue is gated on count<BUF_DEPTH.
  - Pointers wrap modulo 2.
  - inst_out and inst_pc show the head entry. They are 0 when empty.
- Arithmetic: the block performs no addition itself. PC wrap-around follows the adder (modulo 2^XLEN).
- A response in state REQ is a protocol error. It is ignored, and the bench flags it with an assertion.
- Reset mid-fetch: everything returns to its reset value, and the outstanding response is not tracked. Memory must also be reset.

Decomposition:
- Shared package riscv_pkg:
  - Constants XLEN, INSTR_W, RESET_PC.
  - Enum fetch_state_t {REQ, WAIT, DROP}.
  - Typedef fetch_entry_t {pc[XLEN], instr[INSTR_W]}.
- Sub-module fetch_buffer: 2-entry FIFO of fetch_entry_t with push, pop, flush, count, and an async active-low reset.

Test Plan:
1. Reset with RESET_PC=0x1000, ready=1, rsp 1 cycle later, inst_ready=1 -> pc_out goes 0x1000, 0x1004, 0x1008; inst_pc follows 0x1000, 0x1004 with the returned instructions in order.
2. inst_ready=0 for 10 cycles -> exactly 2 entries are buffered and imem_req_valid=0 while count=2. Releasing inst_ready drains 0x1000 then 0x1004 with no loss.
3. branch_taken with branch_target=0x2000 while in WAIT -> the next response is dropped, inst_valid=0 the next cycle, and the next request address is 0x2000.
4. branch_taken in the same cycle as imem_rsp_valid -> the response is discarded, state is REQ, and pc_out=target.
5. stall=1 for 5 cycles in WAIT -> the outstanding response is buffered, imem_req_valid stays 0, and pc_out is held. Normal fetch resumes after stall=0.
6. Assert reset in WAIT with 1 entry buffered -> pc_out=RESET_PC and inst_valid=0 immediately (async), and fetch restarts from RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, reset PC, fetch FSM states and fetch-buffer entry type.
//   XLEN          - PC and adder-result width
//   INSTR_W       - instruction width
//   RESET_PC      - default PC loaded on reset
//   fetch_state_t - REQ (may issue), WAIT (one outstanding), DROP (outstanding, discard)
//   fetch_entry_t - buffered {pc, instr} pair handed to decode
package riscv_pkg;

    localparam int unsigned       XLEN     = 64;
    localparam int unsigned       INSTR_W  = 32;
    localparam logic [XLEN-1:0]   RESET_PC = 64'h0;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of fetched {pc, instr} pairs between fetch and decode.
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   push  - write din at the tail (never asserted when full)
//   din   - entry to write
//   pop   - drop the head entry (never asserted when empty)
//   flush - discard all entries; wins over push and pop
//   head  - head entry, all zeros when empty
//   count - number of valid entries (0..2)
module fetch_buffer
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [2];
    logic         wp;
    logic         rp;

    // Single-bit pointers wrap modulo 2 for free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop)
                rp <= ~rp;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = (count == 2'd0) ? '0 : mem[rp];

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, next-PC select, single-outstanding imem fetch and 2-entry decode buffer.
//   clk            - rising-edge clock
//   reset          - asynchronous active-low reset
//   pc_out         - current PC; adder input and imem request address
//   pc_plus4       - pc_out+4 from the external adder
//   branch_target  - redirect target from the external adder
//   branch_taken   - one-cycle redirect strobe; flushes the buffer
//   stall          - suppresses new requests
//   imem_req_valid - request valid (combinational), address is pc_out
//   imem_req_ready - memory accepts the request
//   imem_rsp_valid - response valid, at least one cycle after accept
//   imem_rsp_instr - response instruction
//   inst_valid     - buffer head valid
//   inst_ready     - decode consumes the head
//   inst_out       - head instruction (0 when empty)
//   inst_pc        - head PC (0 when empty)
module pc_fetch_unit #(
    parameter int unsigned     XLEN      = riscv_pkg::XLEN,
    parameter int unsigned     INSTR_W   = riscv_pkg::INSTR_W,
    parameter logic [XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [XLEN-1:0]    pc_out,
    input  logic [XLEN-1:0]    pc_plus4,
    input  logic [XLEN-1:0]    branch_target,
    input  logic               branch_taken,
    input  logic               stall,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_instr,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_out,
    output logic [XLEN-1:0]    inst_pc
);

    import riscv_pkg::*;

    fetch_state_t    state;
    logic [XLEN-1:0] tag;
    logic [1:0]      count;
    logic            push;
    logic            pop;
    fetch_entry_t    din;
    fetch_entry_t    head;

    // Gating on count keeps a push from ever landing on a full buffer.
    assign imem_req_valid = reset && state == REQ && !stall && !branch_taken
                            && 32'(count) < BUF_DEPTH;

    // A redirect kills both the response being captured and the pop in the same cycle.
    assign push = state == WAIT && imem_rsp_valid && !branch_taken;
    assign pop  = inst_valid && inst_ready && !branch_taken;
    assign din  = '{pc: tag, instr: imem_rsp_instr};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out <= RESET_PC;
            tag    <= '0;
            state  <= REQ;
        end else if (branch_taken) begin
            pc_out <= branch_target;
            // An outstanding request that has not answered yet must be discarded later.
            state  <= (state == REQ || imem_rsp_valid) ? REQ : DROP;
        end else if (imem_req_valid && imem_req_ready) begin
            pc_out <= pc_plus4;
            tag    <= pc_out;
            state  <= WAIT;
        end else if (state != REQ && imem_rsp_valid) begin
            state <= REQ;
        end
    end

    fetch_buffer u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .flush (branch_taken),
        .head  (head),
        .count (count)
    );

    assign inst_valid = count != 2'd0;
    assign inst_out   = head.instr;
    assign inst_pc    = head.pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized scoreboard bench for pc_fetch_unit against a stream-level fetch model.
module tb_pc_fetch_unit;

    localparam logic [63:0] RPC = 64'h1000;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    typedef struct {
        int n;
        int rdy;
        int ird;
        int stl;
        int br;
        int lat;
    } phase_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] pc_out;
    logic [63:0] pc_plus4;
    logic [63:0] branch_target = '0;
    logic        branch_taken = 1'b0;
    logic        stall = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_instr = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;

    always #5 clk = ~clk;

    // The adder sitting downstream of pc_out.
    assign pc_plus4 = pc_out + 64'd4;

    pc_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_out         (pc_out),
        .pc_plus4       (pc_plus4),
        .branch_target  (branch_target),
        .branch_taken   (branch_taken),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_instr (imem_rsp_instr),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc)
    );

    int checks = 0;
    int errors = 0;

    // Model of the architectural fetch stream.
    ent_t        q[$];
    logic [63:0] next_fetch = RPC;
    logic [63:0] tag_model = '0;
    bit          outstanding = 0;
    bit          killed = 0;
    bit          fire_seen = 0;

    // Memory model state.
    logic [63:0] req_addr = '0;
    bit          pend = 0;
    int          cnt = 0;

    function automatic logic [31:0] mem_fn(input logic [63:0] a);
        return {a[17:2], ~a[33:18]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Monitor: checks DUT outputs against the model and advances it for the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset)
                continue;
            assert (!imem_rsp_valid || outstanding) else $error("response with nothing outstanding");
            chk("pc_out", pc_out, next_fetch);
            chk("req_valid", 64'(imem_req_valid),
                64'(!outstanding && !stall && !branch_taken && q.size() < 2));
            chk("inst_valid", 64'(inst_valid), 64'(q.size() != 0));
            if (q.size() == 0) begin
                chk("empty_pc", inst_pc, 64'h0);
                chk("empty_instr", 64'(inst_out), 64'h0);
            end
            if (inst_valid && inst_ready && q.size() != 0) begin
                chk("head_pc", inst_pc, q[0].pc);
                chk("head_instr", 64'(inst_out), 64'(q[0].ins));
                if (!branch_taken)
                    void'(q.pop_front());
            end
            if (imem_rsp_valid && outstanding) begin
                if (!killed && !branch_taken)
                    q.push_back('{pc: tag_model, ins: mem_fn(tag_model)});
                outstanding = 0;
                killed      = 0;
            end
            if (branch_taken) begin
                q.delete();
                next_fetch = branch_target;
                if (outstanding)
                    killed = 1;
            end
            fire_seen = imem_req_valid && imem_req_ready;
            if (fire_seen) begin
                req_addr    = pc_out;
                tag_model   = next_fetch;
                next_fetch  = next_fetch + 64'd4;
                outstanding = 1;
                killed      = 0;
            end
        end
    end

    // One clock of stimulus: memory responder plus randomized control inputs.
    task automatic drive(input phase_t p);
        @(posedge clk);
        #1;
        if (imem_rsp_valid)
            pend = 0;
        if (fire_seen) begin
            pend = 1;
            cnt  = $urandom_range(0, p.lat);
        end
        fire_seen      = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_instr = '0;
        if (pend) begin
            if (cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_instr = mem_fn(req_addr);
            end else begin
                cnt--;
            end
        end
        imem_req_ready = pct(p.rdy);
        inst_ready     = pct(p.ird);
        stall          = pct(p.stl);
        branch_taken   = pct(p.br);
        case ($urandom_range(0, 2))
            0:       branch_target = 64'h2000;
            1:       branch_target = 64'hFFFF_FFFF_FFFF_FFF8;
            default: branch_target = {32'h0, $urandom} & ~64'h3;
        endcase
    endtask

    phase_t ph[6] = '{
        '{30,  100, 100, 0,  0,  0},
        '{20,  100, 0,   0,  0,  0},
        '{60,  100, 100, 0,  20, 2},
        '{60,  70,  60,  30, 10, 3},
        '{40,  100, 100, 50, 0,  2},
        '{200, 60,  50,  20, 8,  3}
    };

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        bit hit;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_pc", pc_out, RPC);
        chk("rst_inst_valid", 64'(inst_valid), 64'h0);
        chk("rst_inst_out", 64'(inst_out), 64'h0);
        chk("rst_inst_pc", inst_pc, 64'h0);
        chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
        @(negedge clk);
        #2;
        reset = 1'b1;

        foreach (ph[i])
            repeat (ph[i].n) drive(ph[i]);

        // Reset while one entry is buffered and a request is outstanding.
        drive('{1, 0, 0, 0, 100, 3});
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            drive('{1, 100, 0, 0, 0, 3});
            hit = outstanding && q.size() == 1;
        end
        chk("reset_setup_reached", 64'(hit), 64'h1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_pc", pc_out, RPC);
        chk("async_rst_inst_valid", 64'(inst_valid), 64'h0);
        chk("async_rst_inst_pc", inst_pc, 64'h0);
        chk("async_rst_req_valid", 64'(imem_req_valid), 64'h0);
        q.delete();
        next_fetch     = RPC;
        outstanding    = 0;
        killed         = 0;
        fire_seen      = 0;
        pend           = 0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        branch_taken   = 1'b0;
        stall          = 1'b0;
        inst_ready     = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;

        repeat (100) drive('{1, 100, 100, 0, 0, 1});
        drive('{1, 0, 100, 0, 0, 1});
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
